// File: rtl/mem_arb.sv
// Two-master memory arbiter: round-robin between the CPU data port (m0) and the
// debug/loader port (m1). m1 can take a bounded exclusive lock; read data is routed back to its owner.
module mem_arb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LOCK_MAX = 256
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  input  logic [3:0]      m0_be_i,
  output logic            m0_gnt_o,
  output logic            m0_rvld_o,
  output logic [XLEN-1:0] m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  input  logic [3:0]      m1_be_i,
  input  logic            m1_lock_i,
  output logic            m1_gnt_o,
  output logic            m1_rvld_o,
  output logic [XLEN-1:0] m1_rdata_o,
  output logic            mem_en_o,
  output logic [3:0]      mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            lock_timeout_o
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {ARB, LOCK, RELEASE} state_t;

  state_t        state_r;
  logic          last_r;     // last granted master: 0 = m0, 1 = m1
  logic [CW-1:0] cnt_r;
  logic          rd_vld_r;
  logic          rd_own_r;   // owner of the read in flight: 0 = m0, 1 = m1
  logic          gnt0;
  logic          gnt1;
  logic          lock_hit;

  // Grants are gated by reset so nothing reaches memory while rst_n_i is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n_i) begin
      case (state_r)
        ARB: begin
          if (m0_req_i && m1_req_i) begin
            gnt0 = last_r;
            gnt1 = !last_r;
          end else begin
            gnt0 = m0_req_i;
            gnt1 = m1_req_i;
          end
        end
        LOCK:    gnt1 = m1_req_i;
        RELEASE: gnt0 = m0_req_i;
        default: ;
      endcase
    end
  end

  assign lock_hit = (state_r == LOCK) && m1_lock_i && (cnt_r == CW'(LOCK_MAX));

  assign m0_gnt_o       = gnt0;
  assign m1_gnt_o       = gnt1;
  assign lock_timeout_o = lock_hit;

  always_comb begin
    mem_en_o    = gnt0 | gnt1;
    mem_we_o    = '0;
    mem_addr_o  = m0_addr_i;
    mem_wdata_o = m0_wdata_i;
    if (gnt1) begin
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_we_o    = m1_be_i & {4{m1_we_i}};
    end else if (gnt0) begin
      mem_we_o    = m0_be_i & {4{m0_we_i}};
    end
  end

  assign m0_rdata_o = mem_rdata_i;
  assign m1_rdata_o = mem_rdata_i;
  assign m0_rvld_o  = rd_vld_r && !rd_own_r;
  assign m1_rvld_o  = rd_vld_r &&  rd_own_r;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= ARB;
      last_r   <= 1'b1;
      cnt_r    <= '0;
      rd_vld_r <= 1'b0;
      rd_own_r <= 1'b0;
    end else begin
      if (gnt0) begin
        last_r <= 1'b0;
      end else if (gnt1) begin
        last_r <= 1'b1;
      end
      rd_vld_r <= (gnt0 && !m0_we_i) || (gnt1 && !m1_we_i);
      if (gnt0 || gnt1) begin
        rd_own_r <= gnt1;
      end
      case (state_r)
        ARB: begin
          if (gnt1 && m1_lock_i) begin
            state_r <= LOCK;
            cnt_r   <= CW'(1);
          end
        end
        LOCK: begin
          if (!m1_lock_i) begin
            state_r <= ARB;
          end else if (lock_hit) begin
            state_r <= RELEASE;
          end else if (cnt_r != CW'(LOCK_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RELEASE: begin
          // m0 is owed the next turn whether or not it took this slot.
          state_r <= ARB;
          last_r  <= 1'b0;
        end
        default: state_r <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: per-cycle expectations are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_mem_arb;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        r0, w0, r1, w1, lock;
  logic [31:0] a0, d0, a1, d1;
  logic [3:0]  be0, be1;

  logic        a_g0, a_g1, a_v0, a_v1, a_en, a_to;
  logic [3:0]  a_we;
  logic [31:0] a_rd0, a_rd1, a_addr, a_wd, a_mrd;
  logic        b_g0, b_g1, b_v0, b_v1, b_en, b_to;
  logic [3:0]  b_we;
  logic [31:0] b_rd0, b_rd1, b_addr, b_wd, b_mrd;

  mem_arb #(.XLEN(32)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(r0), .m0_we_i(w0), .m0_addr_i(a0), .m0_wdata_i(d0), .m0_be_i(be0),
    .m0_gnt_o(a_g0), .m0_rvld_o(a_v0), .m0_rdata_o(a_rd0),
    .m1_req_i(r1), .m1_we_i(w1), .m1_addr_i(a1), .m1_wdata_i(d1), .m1_be_i(be1),
    .m1_lock_i(lock), .m1_gnt_o(a_g1), .m1_rvld_o(a_v1), .m1_rdata_o(a_rd1),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wd),
    .mem_rdata_i(a_mrd), .lock_timeout_o(a_to)
  );

  mem_arb #(.XLEN(32), .LOCK_MAX(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(r0), .m0_we_i(w0), .m0_addr_i(a0), .m0_wdata_i(d0), .m0_be_i(be0),
    .m0_gnt_o(b_g0), .m0_rvld_o(b_v0), .m0_rdata_o(b_rd0),
    .m1_req_i(r1), .m1_we_i(w1), .m1_addr_i(a1), .m1_wdata_i(d1), .m1_be_i(be1),
    .m1_lock_i(lock), .m1_gnt_o(b_g1), .m1_rvld_o(b_v1), .m1_rdata_o(b_rd1),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wd),
    .mem_rdata_i(b_mrd), .lock_timeout_o(b_to)
  );

  // Memory model: a read returns address ^ K on the following cycle.
  always @(posedge clk) begin
    if (a_en && a_we == 4'b0000) a_mrd <= a_addr ^ K;
    if (b_en && b_we == 4'b0000) b_mrd <= b_addr ^ K;
  end

  typedef struct {
    bit          sel;
    bit          g0, g1;
    logic [3:0]  we;
    logic [31:0] ea, wd;
    bit          to, v0, v1;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("m0_gnt", 32'(e.sel ? b_g0 : a_g0), 32'(e.g0));
      chk("m1_gnt", 32'(e.sel ? b_g1 : a_g1), 32'(e.g1));
      chk("mem_en", 32'(e.sel ? b_en : a_en), 32'(e.g0 | e.g1));
      chk("mem_we", 32'(e.sel ? b_we : a_we), 32'(e.we));
      chk("lock_timeout", 32'(e.sel ? b_to : a_to), 32'(e.to));
      chk("m0_rvld", 32'(e.sel ? b_v0 : a_v0), 32'(e.v0));
      chk("m1_rvld", 32'(e.sel ? b_v1 : a_v1), 32'(e.v1));
      if (e.g0 || e.g1) chk("mem_addr", e.sel ? b_addr : a_addr, e.ea);
      if (e.we != 4'b0000) chk("mem_wdata", e.sel ? b_wd : a_wd, e.wd);
      if (e.v0) chk("m0_rdata", e.sel ? b_rd0 : a_rd0, e.rd);
      if (e.v1) chk("m1_rdata", e.sel ? b_rd1 : a_rd1, e.rd);
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic ex(input bit sel, input bit g0, input bit g1, input logic [3:0] we,
                    input logic [31:0] ea, input logic [31:0] wd, input bit to,
                    input bit v0, input bit v1, input logic [31:0] rd);
    exp_t e;
    e.sel = sel; e.g0 = g0; e.g1 = g1; e.we = we; e.ea = ea; e.wd = wd;
    e.to = to; e.v0 = v0; e.v1 = v1; e.rd = rd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit sel);
    ex(sel, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic m0(input bit r, input bit w, input logic [31:0] a, input logic [3:0] be);
    r0 = r; w0 = w; a0 = a; d0 = 32'h1111_0000 | a; be0 = be;
  endtask

  task automatic m1(input bit r, input bit w, input logic [31:0] a, input logic [3:0] be,
                    input bit lk);
    r1 = r; w1 = w; a1 = a; d1 = 32'h2222_0000 | a; be1 = be; lock = lk;
  endtask

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  initial begin
    m0(0, 0, 0, 4'h0);
    m1(0, 0, 0, 4'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset holds all outputs low even with a request present.
    m0(1, 0, 32'h0, 4'hF);
    idle(A);
    idle(A);

    // Both masters reading continuously: strict alternation starting with m0.
    rst_n = 1'b1;
    m0(1, 0, 32'h0, 4'hF);
    m1(1, 0, 32'h100, 4'hF, 0);
    ex(A, 1, 0, 4'h0, 32'h0,   0, 0, 0, 0, 0);
    ex(A, 0, 1, 4'h0, 32'h100, 0, 0, 1, 0, K);
    ex(A, 1, 0, 4'h0, 32'h0,   0, 0, 0, 1, K ^ 32'h100);
    ex(A, 0, 1, 4'h0, 32'h100, 0, 0, 1, 0, K);
    ex(A, 1, 0, 4'h0, 32'h0,   0, 0, 0, 1, K ^ 32'h100);
    ex(A, 0, 1, 4'h0, 32'h100, 0, 0, 1, 0, K);
    m0(0, 0, 0, 4'h0);
    m1(0, 0, 0, 4'h0, 0);
    ex(A, 0, 0, 4'h0, 0, 0, 0, 0, 1, K ^ 32'h100);
    idle(A);

    // Writes: byte enables pass through, no read-valid follows.
    m1(1, 1, 32'h40, 4'b0011, 0);
    ex(A, 0, 1, 4'b0011, 32'h40, 32'h2222_0040, 0, 0, 0, 0);
    ex(A, 0, 1, 4'b0011, 32'h40, 32'h2222_0040, 0, 0, 0, 0);
    m1(0, 0, 0, 4'h0, 0);
    m0(1, 1, 32'h44, 4'b1100);
    ex(A, 1, 0, 4'b1100, 32'h44, 32'h1111_0044, 0, 0, 0, 0);
    m0(0, 0, 0, 4'h0);
    idle(A);

    // m1 wins after m0; m0's request withdrawn before grant leaves no trace.
    m0(1, 0, 32'h8, 4'hF);
    m1(1, 0, 32'h104, 4'hF, 0);
    ex(A, 0, 1, 4'h0, 32'h104, 0, 0, 0, 0, 0);
    m0(0, 0, 0, 4'h0);
    m1(0, 0, 0, 4'h0, 0);
    ex(A, 0, 0, 4'h0, 0, 0, 0, 0, 1, K ^ 32'h104);
    idle(A);

    // Lock held for 10 cycles blocks m0; m0 granted right after release.
    m0(1, 1, 32'h48, 4'hF);
    ex(A, 1, 0, 4'hF, 32'h48, 32'h1111_0048, 0, 0, 0, 0);
    m0(1, 0, 32'h10, 4'hF);
    m1(1, 1, 32'h200, 4'hF, 1);
    for (int i = 0; i < 10; i++) ex(A, 0, 1, 4'hF, 32'h200, 32'h2222_0200, 0, 0, 0, 0);
    m1(0, 0, 0, 4'h0, 0);
    idle(A);
    ex(A, 1, 0, 4'h0, 32'h10, 0, 0, 0, 0, 0);
    m0(0, 0, 0, 4'h0);
    ex(A, 0, 0, 4'h0, 0, 0, 0, 1, 0, K ^ 32'h10);

    // Reset in the cycle after an m0 read grant swallows the response.
    m0(1, 0, 32'h20, 4'hF);
    ex(A, 1, 0, 4'h0, 32'h20, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    idle(A);
    idle(A);
    rst_n = 1'b1;
    m0(1, 0, 32'h24, 4'hF);
    m1(1, 0, 32'h108, 4'hF, 0);
    ex(A, 1, 0, 4'h0, 32'h24, 0, 0, 0, 0, 0);
    m0(0, 0, 0, 4'h0);
    m1(0, 0, 0, 4'h0, 0);
    ex(A, 0, 0, 4'h0, 0, 0, 0, 1, 0, K ^ 32'h24);

    // LOCK_MAX = 4 instance: forced release, single m0 slot, then re-lock.
    rst_n = 1'b0;
    idle(A);
    rst_n = 1'b1;
    m0(1, 0, 32'h30, 4'hF);
    m1(1, 1, 32'h300, 4'hF, 1);
    ex(B, 1, 0, 4'h0, 32'h30,  0,            0, 0, 0, 0);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 1, 0, K ^ 32'h30);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 0, 0, 0);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 0, 0, 0);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 0, 0, 0);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 1, 0, 0, 0);
    ex(B, 1, 0, 4'h0, 32'h30,  0,            0, 0, 0, 0);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 1, 0, K ^ 32'h30);
    ex(B, 0, 1, 4'hF, 32'h300, 32'h2222_0300, 0, 0, 0, 0);
    m0(0, 0, 0, 4'h0);
    m1(0, 0, 0, 4'h0, 0);
    idle(B);
    idle(B);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
